// File: rtl/bp_fe_bht_update_queue.sv
// Buffers branch-resolution updates for the BHT write port in a small FIFO,
// filtering redundant updates and counting filtered and dropped ones.
module bp_fe_bht_update_queue #(
  parameter int bht_idx_width_p    = 6,
  parameter int bht_offset_width_p = 1,
  parameter int ghist_width_p      = 2,
  parameter int bht_row_els_p      = 2,
  parameter int els_p              = 4,
  parameter int cnt_width_p        = 16,
  localparam int bht_row_width_p   = 2*bht_row_els_p
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          init_done_i,
  input  logic                          flush_i,
  input  logic                          in_v_i,
  input  logic [bht_idx_width_p-1:0]    in_idx_i,
  input  logic [bht_offset_width_p-1:0] in_offset_i,
  input  logic [ghist_width_p-1:0]      in_ghist_i,
  input  logic [bht_row_width_p-1:0]    in_val_i,
  input  logic                          in_correct_i,
  output logic                          w_v_o,
  output logic [bht_idx_width_p-1:0]    w_idx_o,
  output logic [bht_offset_width_p-1:0] w_offset_o,
  output logic [ghist_width_p-1:0]      w_ghist_o,
  output logic [bht_row_width_p-1:0]    w_val_o,
  output logic                          w_correct_o,
  input  logic                          w_yumi_i,
  output logic [cnt_width_p-1:0]        drop_cnt_o,
  output logic [cnt_width_p-1:0]        filter_cnt_o
);

  localparam int ptr_w   = $clog2(els_p);
  localparam int entry_w = bht_idx_width_p + bht_offset_width_p + ghist_width_p
                         + bht_row_width_p + 1;

  typedef enum logic {e_wait, e_run} state_e;

  function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] x,
                                                     input logic en);
    return (en && !(&x)) ? x + cnt_width_p'(1) : x;
  endfunction

  state_e                state_r, state_n;
  logic [entry_w-1:0]    mem [els_p];
  logic [entry_w-1:0]    head_r, head_n, in_entry;
  logic [ptr_w-1:0]      wptr_r, rptr_r, wptr_n, rptr_n;
  logic [ptr_w:0]        count_r, count_n;
  logic [1:0]            ctr;
  logic                  full, empty, filtered, enq, deq, drop;

  assign in_entry = {in_idx_i, in_offset_i, in_ghist_i, in_val_i, in_correct_i};
  assign ctr      = in_val_i[{in_offset_i, 1'b0} +: 2];
  assign filtered = in_v_i & in_correct_i & ((ctr == 2'b11) | (ctr == 2'b00));
  assign full     = (count_r == (ptr_w+1)'(els_p));
  assign empty    = (count_r == '0);
  assign w_v_o    = (state_r == e_run) & ~empty;
  assign deq      = w_v_o & w_yumi_i;
  // A flush swallows any same-cycle update without counting it.
  assign enq      = in_v_i & ~filtered & ~flush_i & (~full | deq);
  assign drop     = in_v_i & ~filtered & ~flush_i & full & ~deq;

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_wait:  if (init_done_i) state_n = e_run;
      e_run:   state_n = e_run;
      default: state_n = e_wait;
    endcase
  end

  always_comb begin
    rptr_n  = rptr_r + ptr_w'(deq);
    wptr_n  = wptr_r + ptr_w'(enq);
    count_n = count_r + (ptr_w+1)'(enq) - (ptr_w+1)'(deq);
    head_n  = '0;
    if (flush_i) begin
      rptr_n  = '0;
      wptr_n  = '0;
      count_n = '0;
    end else if (count_n != '0) begin
      // Bypass when the slot being written is the next head (queue drains to empty).
      if (enq && (rptr_n == wptr_r)) head_n = in_entry;
      else                           head_n = mem[rptr_n];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= e_wait;
      rptr_r       <= '0;
      wptr_r       <= '0;
      count_r      <= '0;
      head_r       <= '0;
      drop_cnt_o   <= '0;
      filter_cnt_o <= '0;
    end else begin
      state_r      <= state_n;
      rptr_r       <= rptr_n;
      wptr_r       <= wptr_n;
      count_r      <= count_n;
      head_r       <= head_n;
      drop_cnt_o   <= sat_inc(drop_cnt_o, drop);
      filter_cnt_o <= sat_inc(filter_cnt_o, filtered & ~flush_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr_r] <= in_entry;
  end

  assign {w_idx_o, w_offset_o, w_ghist_o, w_val_o, w_correct_o} = head_r;

endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
// Bench for bp_fe_bht_update_queue: directed table, hand sequences and
// randomized traffic compared against a queue-based reference model.
module tb_bp_fe_bht_update_queue;

  typedef struct packed {
    logic [5:0] idx;
    logic       off;
    logic [1:0] ghist;
    logic [3:0] val;
    logic       correct;
  } ent_t;

  typedef struct {
    logic       v;
    logic [5:0] idx;
    logic       off;
    logic [3:0] val;
    logic       corr;
    logic       init;
    logic       fl;
    logic       yu;
    logic       exp_wv;
    logic [5:0] exp_idx;
    int         exp_filt;
    int         exp_drop;
  } vec_t;

  logic        clk_i = 0;
  logic        reset_i, init_done_i, flush_i, in_v_i, in_correct_i, w_yumi_i;
  logic [5:0]  in_idx_i, w_idx_o;
  logic        in_offset_i, w_offset_o;
  logic [1:0]  in_ghist_i, w_ghist_o;
  logic [3:0]  in_val_i, w_val_o;
  logic        w_v_o, w_correct_o;
  logic [15:0] drop_cnt_o, filter_cnt_o;

  bp_fe_bht_update_queue dut (
    .clk_i(clk_i), .reset_i(reset_i), .init_done_i(init_done_i), .flush_i(flush_i),
    .in_v_i(in_v_i), .in_idx_i(in_idx_i), .in_offset_i(in_offset_i),
    .in_ghist_i(in_ghist_i), .in_val_i(in_val_i), .in_correct_i(in_correct_i),
    .w_v_o(w_v_o), .w_idx_o(w_idx_o), .w_offset_o(w_offset_o), .w_ghist_o(w_ghist_o),
    .w_val_o(w_val_o), .w_correct_o(w_correct_o), .w_yumi_i(w_yumi_i),
    .drop_cnt_o(drop_cnt_o), .filter_cnt_o(filter_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_checks = 0;
  int   n_err = 0;
  ent_t q[$];
  bit   run;
  int   m_drop, m_filt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    run = 0;
    m_drop = 0;
    m_filt = 0;
  endtask

  task automatic check_all();
    ent_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk("w_v", w_v_o, run && q.size() > 0);
    chk("w_idx", w_idx_o, h.idx);
    chk("w_offset", w_offset_o, h.off);
    chk("w_ghist", w_ghist_o, h.ghist);
    chk("w_val", w_val_o, h.val);
    chk("w_correct", w_correct_o, h.correct);
    chk("drop_cnt", drop_cnt_o, m_drop);
    chk("filter_cnt", filter_cnt_o, m_filt);
  endtask

  // One clock: drive at negedge, model the edge, compare at the next negedge.
  task automatic cyc(input logic v, input ent_t e, input logic init, input logic fl,
                     input logic yu);
    bit deq;
    int c;
    deq = yu && run && q.size() > 0;
    in_v_i = v; in_idx_i = e.idx; in_offset_i = e.off; in_ghist_i = e.ghist;
    in_val_i = e.val; in_correct_i = e.correct;
    init_done_i = init; flush_i = fl; w_yumi_i = deq;
    @(posedge clk_i);
    if (fl) q.delete();
    else begin
      if (deq) void'(q.pop_front());
      if (v) begin
        c = (int'(e.val) >> (2 * int'(e.off))) & 3;
        if (e.correct && (c == 3 || c == 0)) begin
          if (m_filt < 65535) m_filt++;
        end else if (q.size() < 4) q.push_back(e);
        else if (m_drop < 65535) m_drop++;
      end
    end
    if (init) run = 1;
    @(negedge clk_i);
    check_all();
  endtask

  function automatic ent_t mk(input logic [5:0] idx, input logic off,
                              input logic [3:0] val, input logic corr);
    ent_t e;
    e.idx = idx; e.off = off; e.ghist = idx[1:0]; e.val = val; e.correct = corr;
    return e;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  vec_t tbl[11];
  ent_t pushed[4];
  int   sd, sf;

  initial begin
    tbl[0]  = '{1, 6'd1, 0, 4'b0001, 0, 0, 0, 0, 0, 6'd1, 0, 0};
    tbl[1]  = '{1, 6'd2, 1, 4'b0100, 1, 0, 0, 0, 0, 6'd1, 0, 0};
    tbl[2]  = '{0, 6'd0, 0, 4'b0000, 0, 1, 0, 0, 1, 6'd1, 0, 0};
    tbl[3]  = '{1, 6'd3, 1, 4'b1100, 1, 1, 0, 0, 1, 6'd1, 1, 0};
    tbl[4]  = '{1, 6'd4, 0, 4'b1101, 1, 0, 0, 0, 1, 6'd1, 1, 0};
    tbl[5]  = '{1, 6'd5, 0, 4'b0000, 1, 0, 0, 0, 1, 6'd1, 2, 0};
    tbl[6]  = '{1, 6'd6, 0, 4'b0010, 1, 0, 0, 0, 1, 6'd1, 2, 0};
    tbl[7]  = '{1, 6'd7, 0, 4'b0011, 0, 0, 0, 0, 1, 6'd1, 2, 1};
    tbl[8]  = '{1, 6'd8, 0, 4'b0001, 0, 0, 0, 1, 1, 6'd2, 2, 1};
    tbl[9]  = '{1, 6'd9, 0, 4'b0001, 0, 0, 1, 0, 0, 6'd0, 2, 1};
    tbl[10] = '{0, 6'd0, 0, 4'b0000, 0, 0, 0, 0, 0, 6'd0, 2, 1};

    reset_i = 1; init_done_i = 0; flush_i = 0; in_v_i = 0; in_idx_i = 0;
    in_offset_i = 0; in_ghist_i = 0; in_val_i = 0; in_correct_i = 0; w_yumi_i = 0;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("reset_w_v", w_v_o, 0);
    chk("reset_drop", drop_cnt_o, 0);
    chk("reset_filter", filter_cnt_o, 0);
    chk("reset_w_val", w_val_o, 0);
    reset_i = 0;
    @(negedge clk_i);

    // Directed table: wait-state hold, filtering, full drop, enqueue-on-full, flush.
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].v, mk(tbl[i].idx, tbl[i].off, tbl[i].val, tbl[i].corr),
          tbl[i].init, tbl[i].fl, tbl[i].yu);
      chk($sformatf("tbl%0d_w_v", i), w_v_o, tbl[i].exp_wv);
      chk($sformatf("tbl%0d_w_idx", i), w_idx_o, tbl[i].exp_idx);
      chk($sformatf("tbl%0d_filter", i), filter_cnt_o, tbl[i].exp_filt);
      chk($sformatf("tbl%0d_drop", i), drop_cnt_o, tbl[i].exp_drop);
    end

    // Stall with a full queue, then drain in order.
    for (int i = 0; i < 4; i++) begin
      pushed[i] = mk(6'(20 + i), i[0], 4'(i + 4), 0);
      cyc(1, pushed[i], 1, 0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(0, '0, 1, 0, 0);
      chk("stall_w_v", w_v_o, 1);
      chk("stall_head", {w_idx_o, w_offset_o, w_ghist_o, w_val_o, w_correct_o}, pushed[0]);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 1, 0, 1);
      if (i < 3) chk("drain_order", w_idx_o, pushed[i+1].idx);
    end
    chk("drain_empty", w_v_o, 0);

    // Flush with three entries and a same-cycle update.
    for (int i = 0; i < 3; i++) cyc(1, mk(6'(30 + i), 0, 4'b0110, 0), 1, 0, 0);
    sd = m_drop; sf = m_filt;
    cyc(1, mk(6'd40, 0, 4'b0110, 0), 1, 1, 1);
    chk("flush_w_v", w_v_o, 0);
    chk("flush_drop", drop_cnt_o, sd);
    chk("flush_filter", filter_cnt_o, sf);
    cyc(0, '0, 1, 0, 0);
    chk("flush_stays_empty", w_v_o, 0);

    // Asynchronous reset between clock edges.
    cyc(1, mk(6'd50, 0, 4'b0110, 0), 1, 0, 0);
    cyc(1, mk(6'd51, 0, 4'b0110, 0), 1, 0, 0);
    in_v_i = 0; w_yumi_i = 0; init_done_i = 0;
    #2 reset_i = 1;
    #1;
    chk("async_rst_w_v", w_v_o, 0);
    chk("async_rst_w_idx", w_idx_o, 0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 0;
    cyc(1, mk(6'd52, 1, 4'b0110, 0), 0, 0, 0);
    chk("post_rst_wait", w_v_o, 0);
    cyc(0, '0, 1, 0, 0);
    chk("post_rst_run", w_idx_o, 52);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) != 0,
          mk(6'($urandom), 1'($urandom), 4'($urandom), 1'($urandom)),
          ($urandom % 16) == 0, ($urandom % 30) == 0, ($urandom % 3) == 0);
      if (i == 300) begin
        in_v_i = 0; w_yumi_i = 0; init_done_i = 0; flush_i = 0;
        #2 reset_i = 1;
        #1;
        chk("rand_rst_w_v", w_v_o, 0);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
